change_dispenser: RTL and testbench
===================================

# change_dispenser

Output-side companion to the vending machine FSM: consumes its vend strobe and change amount, then drives the soda release solenoid and coin ejectors. Returns change as dime/nickel coins, one coin per request/acknowledge handshake with the ejector hardware. It sits between the vending machine core (`soda`/`chan` outputs) and the mechanical ejector interface.

## Interface
- `SODA_CYCLES`, default 4: cycles `soda_o` is held high per vend; legal range 1..255.
- `clk  in  1`: sole clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `vend_i  in  1`: vend strobe from the vending machine, 1 cycle.
- `chan_i  in  3`: change owed, in nickels (0..7 = 0..35 cents); sampled only when `vend_i` is accepted.
- `ack_i  in  1`: ejector acknowledge; high means the requested coin has dropped.
- `dime_empty_i  in  1`: dime tube empty.
- `nick_empty_i  in  1`: nickel tube empty.
- `soda_o  out  1`: soda release solenoid drive.
- `dime_o  out  1`: dime eject request, level.
- `nick_o  out  1`: nickel eject request, level.
- `busy_o  out  1`: transaction in progress.
- `rem_o  out  3`: change still owed, in nickels.
- `fault_o  out  1`: change could not be completed; sticky.
- `drop_o  out  1`: 1-cycle pulse when `vend_i` arrives while busy.

## Operation
- States:
  - IDLE: accepts `vend_i`.
  - SODA: holds `soda_o`.
  - EJECT: holds a request until `ack_i`.
  - GAP: waits for `ack_i` to go low.
- IDLE, `vend_i`=1: load `rem_o` ← `chan_i`, clear `fault_o`, counter ← 0, go to SODA.
- SODA: `soda_o`=1 and the counter increments. When the counter reaches `SODA_CYCLES`−1, run the coin-select decision.
- Coin-select decision, first match wins:
  - `rem_o`=0: go to IDLE.
  - `rem_o`≥2 and `dime_empty_i`=0: go to EJECT with `dime_o`=1.
  - `nick_empty_i`=0: go to EJECT with `nick_o`=1.
  - Otherwise: `fault_o` ← 1, go to IDLE. `rem_o` keeps the undelivered amount.
- EJECT: the request is held stable. On a cycle with `ack_i`=1, `rem_o` decrements by 2 (dime) or 1 (nickel), and the FSM goes to GAP.
- GAP: no request. Once `ack_i`=0 is sampled, run the coin-select decision.
- Only one of `dime_o`/`nick_o` is high at a time; never both.
- Empty flags are sampled only at a decision point. An empty flag rising during EJECT does not abort the current request.
- `ack_i` outside EJECT is ignored.
- `vend_i` outside IDLE: ignored, `drop_o` pulses the next cycle, and `rem_o` is unchanged.
- `rem_o` never underflows. A dime is issued only when `rem_o`≥2.
- `busy_o` = (state ≠ IDLE).

## Timing
- Reset value of every output is 0, including `rem_o` and `fault_o`.
- Reset mid-transaction: all outputs drop asynchronously and the owed change is discarded.
- `vend_i` sampled high at edge N:
  - `busy_o` and `soda_o` are high from N+1.
  - `soda_o` stays high for exactly `SODA_CYCLES` cycles.
- First coin request (or `busy_o` low, if `rem_o`=0) at edge N+`SODA_CYCLES`+1.
- `ack_i` high sampled at edge M: request low and `rem_o` updated at M+1.
- `ack_i` low sampled at edge K in GAP: next request (or IDLE) at K+1.
- `fault_o` and `busy_o`=0 are asserted in the same cycle.

## Configuration
- `CHANGE_DIME_EN` defined: dime path active as described.
- `CHANGE_DIME_EN` undefined:
  - `dime_o` is tied to 0 and `dime_empty_i` is ignored.
  - All change is paid in nickels.
  - The `rem_o` decrement is always 1.

## Test plan
Ejector model acks 2 cycles after a request and holds `ack_i` for 1 cycle.
- `vend_i` with `chan_i`=0, `SODA_CYCLES`=4 → `soda_o` high 4 cycles; `busy_o` low at N+5; no coin requests.
- `chan_i`=7 with `CHANGE_DIME_EN` → coin sequence dime, dime, dime, nickel; `rem_o` goes 7→5→3→1→0; `fault_o`=0.
- `chan_i`=4 with `dime_empty_i`=1 → four nickel requests; `rem_o` goes 4→3→2→1→0.
- `chan_i`=3 with both tubes empty after the first dime → `fault_o`=1, `rem_o`=1, `busy_o`=0; the next vend clears `fault_o`.
- `vend_i` during EJECT → `drop_o` 1-cycle pulse; `rem_o` unaffected. Then `rst_n` low during EJECT → all outputs 0 immediately.
- `CHANGE_DIME_EN` undefined, `chan_i`=5 → five nickel requests; `dime_o` never high.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
// Output-side companion to the vending machine core. It takes the vend strobe
// and the change owed, drives the soda solenoid for SODA_CYCLES cycles, then
// pays the change one coin per request/acknowledge handshake with the ejectors.
//
// Build option: define CHANGE_DIME_EN to enable the dime path. When it is
// undefined, dime_o stays low, dime_empty_i is ignored and all change is paid
// in nickels.
module change_dispenser #(
    parameter int unsigned SODA_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vend_i,
    input  logic [2:0] chan_i,
    input  logic       ack_i,
    input  logic       dime_empty_i,
    input  logic       nick_empty_i,
    output logic       soda_o,
    output logic       dime_o,
    output logic       nick_o,
    output logic       busy_o,
    output logic [2:0] rem_o,
    output logic       fault_o,
    output logic       drop_o
);

`ifdef CHANGE_DIME_EN
    localparam bit DimeEn = 1'b1;
`else
    localparam bit DimeEn = 1'b0;
`endif

    // Last counter value of the soda phase; the decision is taken on it.
    localparam logic [7:0] SodaLast = 8'(SODA_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SODA,
        EJECT,
        GAP
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic       fault_q, fault_d;
    logic [7:0] cnt_q, cnt_d;
    logic       coinDime_q, coinDime_d;
    logic       drop_q, drop_d;

    logic       selDime;
    logic       selNick;
    logic       selFault;
    logic [2:0] coinValue;

    // Coin-select: idle when nothing is owed, prefer a dime when at least two
    // nickels are owed and dimes are available, else a nickel, else fault.
    always_comb begin
        selDime  = 1'b0;
        selNick  = 1'b0;
        selFault = 1'b0;
        if (rem_q == 3'd0) begin
            selDime = 1'b0;
        end else if (DimeEn && (rem_q >= 3'd2) && !dime_empty_i) begin
            selDime = 1'b1;
        end else if (!nick_empty_i) begin
            selNick = 1'b1;
        end else begin
            selFault = 1'b1;
        end
    end

    // Value of the coin currently being requested, in nickels.
    always_comb begin
        coinValue = 3'd1;
        if (DimeEn && coinDime_q) begin
            coinValue = 3'd2;
        end
    end

    // State and datapath registers; reset discards any owed change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= 3'd0;
            fault_q    <= 1'b0;
            cnt_q      <= 8'd0;
            coinDime_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
            coinDime_q <= coinDime_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state logic: vend acceptance, soda timing, handshake sequencing.
    always_comb begin
        logic decide;
        state_d    = state_q;
        rem_d      = rem_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        coinDime_d = coinDime_q;
        drop_d     = vend_i && (state_q != IDLE);
        decide     = 1'b0;

        case (state_q)
            IDLE: begin
                if (vend_i) begin
                    rem_d   = chan_i;
                    fault_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = SODA;
                end
            end
            SODA: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SodaLast) begin
                    decide = 1'b1;
                end
            end
            EJECT: begin
                if (ack_i) begin
                    rem_d   = rem_q - coinValue;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!ack_i) begin
                    decide = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (decide) begin
            if (selDime) begin
                coinDime_d = 1'b1;
                state_d    = EJECT;
            end else if (selNick) begin
                coinDime_d = 1'b0;
                state_d    = EJECT;
            end else begin
                coinDime_d = 1'b0;
                state_d    = IDLE;
                if (selFault) begin
                    fault_d = 1'b1;
                end
            end
        end
    end

    // Outputs are decoded from registered state only, so they fall with reset.
    always_comb begin
        soda_o  = (state_q == SODA);
        dime_o  = DimeEn && (state_q == EJECT) && coinDime_q;
        nick_o  = (state_q == EJECT) && !coinDime_q;
        busy_o  = (state_q != IDLE);
        rem_o   = rem_q;
        fault_o = fault_q;
        drop_o  = drop_q;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed scenarios plus randomized vends,
// each checked against a transaction-level model of the change payout.
module tb_change_dispenser;

    localparam int SC = 4;

`ifdef CHANGE_DIME_EN
    localparam bit DIME = 1'b1;
`else
    localparam bit DIME = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vend_i;
    logic [2:0] chan_i;
    logic       ack_i;
    logic       dime_empty_i;
    logic       nick_empty_i;
    logic       soda_o;
    logic       dime_o;
    logic       nick_o;
    logic       busy_o;
    logic [2:0] rem_o;
    logic       fault_o;
    logic       drop_o;

    int checks   = 0;
    int failures = 0;

    change_dispenser #(.SODA_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vend_i      (vend_i),
        .chan_i      (chan_i),
        .ack_i       (ack_i),
        .dime_empty_i(dime_empty_i),
        .nick_empty_i(nick_empty_i),
        .soda_o      (soda_o),
        .dime_o      (dime_o),
        .nick_o      (nick_o),
        .busy_o      (busy_o),
        .rem_o       (rem_o),
        .fault_o     (fault_o),
        .drop_o      (drop_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One complete vend with an ejector that acks two cycles after each
    // request. (d0,n0) are the tube-empty flags seen at the first coin
    // decision; (d1,n1) apply from the first acknowledge onward.
    task automatic applyStimulus(input int chan, input bit d0, input bit n0,
                                 input bit d1, input bit n1);
        int coins[$];
        int rem;
        int idx;
        int expFault;
        int sodaCnt;
        bit de;
        bit ne;

        // Payout model: greedy dimes, then nickels, fault when nothing fits.
        rem      = chan;
        idx      = 0;
        expFault = 0;
        while (rem > 0) begin
            de = (idx == 0) ? d0 : d1;
            ne = (idx == 0) ? n0 : n1;
            if (DIME && rem >= 2 && !de) begin
                coins.push_back(2);
                rem -= 2;
            end else if (!ne) begin
                coins.push_back(1);
                rem -= 1;
            end else begin
                expFault = 1;
                break;
            end
            idx++;
        end

        @(negedge clk);
        vend_i       = 1'b1;
        chan_i       = chan[2:0];
        dime_empty_i = d0;
        nick_empty_i = n0;
        @(negedge clk);
        vend_i = 1'b0;
        checkOutput("busy_start", busy_o, 1);
        checkOutput("fault_cleared", fault_o, 0);
        checkOutput("rem_load", rem_o, chan);

        sodaCnt = 0;
        while (soda_o === 1'b1 && sodaCnt < 300) begin
            sodaCnt++;
            @(negedge clk);
        end
        checkOutput("soda_len", sodaCnt, SC);

        rem = chan;
        foreach (coins[i]) begin
            checkOutput("coin_dime", dime_o, coins[i] == 2);
            checkOutput("coin_nick", nick_o, coins[i] == 1);
            checkOutput("rem_before", rem_o, rem);
            @(negedge clk);
            checkOutput("req_held", {dime_o, nick_o}, (coins[i] == 2) ? 2 : 1);
            ack_i        = 1'b1;
            dime_empty_i = d1;
            nick_empty_i = n1;
            @(negedge clk);
            ack_i = 1'b0;
            rem -= coins[i];
            checkOutput("req_drop", {dime_o, nick_o}, 0);
            checkOutput("rem_after", rem_o, rem);
            @(negedge clk);
        end

        checkOutput("end_busy", busy_o, 0);
        checkOutput("end_fault", fault_o, expFault);
        checkOutput("end_rem", rem_o, rem);
        checkOutput("end_req", {dime_o, nick_o}, 0);
        checkOutput("end_drop", drop_o, 0);
    endtask

    initial begin
        int waitCnt;

        rst_n        = 1'b0;
        vend_i       = 1'b0;
        chan_i       = 3'd0;
        ack_i        = 1'b0;
        dime_empty_i = 1'b0;
        nick_empty_i = 1'b0;
        #12;
        checkOutput("rst_outputs",
                    {soda_o, dime_o, nick_o, busy_o, rem_o, fault_o, drop_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(3, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(6, 1'b1, 1'b1, 1'b1, 1'b1);

        // Randomized vends with occasionally empty tubes.
        for (int t = 0; t < 25; t++) begin
            applyStimulus(int'($urandom_range(0, 7)),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        // Vend while ejecting, then reset in the middle of the request.
        @(negedge clk);
        vend_i       = 1'b1;
        chan_i       = 3'd5;
        dime_empty_i = 1'b0;
        nick_empty_i = 1'b0;
        @(negedge clk);
        vend_i  = 1'b0;
        waitCnt = 0;
        while (!(dime_o || nick_o) && waitCnt < 300) begin
            waitCnt++;
            @(negedge clk);
        end
        checkOutput("eject_reached", waitCnt < 300, 1);
        vend_i = 1'b1;
        chan_i = 3'd2;
        @(negedge clk);
        vend_i = 1'b0;
        checkOutput("drop_pulse", drop_o, 1);
        checkOutput("drop_rem", rem_o, 5);
        checkOutput("drop_req_kept", dime_o || nick_o, 1);
        @(negedge clk);
        checkOutput("drop_one_cycle", drop_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst",
                    {soda_o, dime_o, nick_o, busy_o, rem_o, fault_o, drop_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
